pwr_cntr_ctrl: RTL

Bank of per-net transition (power) counters for the gate/mux library benches. It also contains the readout scheduler that serialises them onto one shared data bus.
- Each library net under test raises a one-cycle event pulse per transition; the block accumulates the pulses in saturating counters.
- On a dump request it snapshots all counters, then streams them out by address with a valid/ack handshake.
- Counting continues during readout.

---
 rtl/pwr_cntr_pkg.sv | 20 ++
 rtl/pwr_cntr_cell.sv | 41 ++++
 rtl/pwr_cntr_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/pwr_cntr_pkg.sv
// pwr_cntr_pkg: shared definitions for the transition-counter bank.
//   - default sizing constants for the counter bank and readout bus
//   - saturation value for the default counter width
//   - readout FSM state encoding
package pwr_cntr_pkg;

    localparam int NUM_CNTR_DEF = 5;
    localparam int ADDR_W_DEF   = 3;
    localparam int CNT_W_DEF    = 32;

    // All-ones value a default-width counter sticks at once it saturates.
    localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/pwr_cntr_cell.sv
// pwr_cntr_cell: one saturating transition counter with sticky overflow.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear of count and overflow (beats inc_i)
//   inc_i         : increment request (already gated by the enable)
//   cnt_o         : live count
//   ovf_o         : set when an increment arrives at all-ones
module pwr_cntr_cell #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (inc_i) begin
            // Hold at all-ones instead of wrapping; remember that it happened.
            if (cnt_q == SAT) ovf_q <= 1'b1;
            else              cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pwr_cntr_ctrl.sv
// pwr_cntr_ctrl: bank of saturating transition counters plus a readout
// scheduler that snapshots the bank on DUMP and streams it out by address.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   ENB        : counting enable (readout is unaffected)
//   EVT        : per-counter increment pulses
//   CLR        : synchronous clear of live counters and OVF
//   DUMP       : readout request, honoured only when idle
//   RD_ACK     : consumer accepts the current word
//   LE/DIR/DATO: word valid / address / snapshot data (0 when LE=0)
//   BUSY       : readout in progress (SEND or FIN)
//   DONE       : one-cycle pulse after the last word is accepted
//   OVF        : sticky saturation flags of the live counters
module pwr_cntr_ctrl
    import pwr_cntr_pkg::*;
#(
    parameter int NUM_CNTR = NUM_CNTR_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                ENB,
    input  logic [NUM_CNTR-1:0] EVT,
    input  logic                CLR,
    input  logic                DUMP,
    input  logic                RD_ACK,
    output logic                LE,
    output logic [ADDR_W-1:0]   DIR,
    output logic [CNT_W-1:0]    DATO,
    output logic                BUSY,
    output logic                DONE,
    output logic [NUM_CNTR-1:0] OVF
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CNTR - 1);

    logic [CNT_W-1:0] cnt    [NUM_CNTR];
    logic [CNT_W-1:0] snap_q [NUM_CNTR];

    state_e            state_q;
    logic              le_q, busy_q, done_q;
    logic [ADDR_W-1:0] dir_q;
    logic [CNT_W-1:0]  dato_q;

    for (genvar g = 0; g < NUM_CNTR; g++) begin : g_cell
        pwr_cntr_cell #(.CNT_W(CNT_W)) u_cell (
            .clk_i  (CLK),
            .rst_ni (RST_N),
            .clr_i  (CLR),
            .inc_i  (ENB & EVT[g]),
            .cnt_o  (cnt[g]),
            .ovf_o  (OVF[g])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            le_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= '0;
            dato_q  <= '0;
            for (int i = 0; i < NUM_CNTR; i++) snap_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (DUMP) begin
                        // cnt[] still holds the pre-edge values here, so this
                        // edge's CLR/EVT never leak into the snapshot. Word 0
                        // is taken straight from the live value because
                        // snap_q is only written at this same edge.
                        for (int i = 0; i < NUM_CNTR; i++) snap_q[i] <= cnt[i];
                        dir_q   <= '0;
                        dato_q  <= cnt[0];
                        le_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (RD_ACK) begin
                        if (dir_q == LAST) begin
                            le_q    <= 1'b0;
                            dato_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else begin
                            dir_q  <= dir_q + 1'b1;
                            dato_q <= snap_q[dir_q + 1'b1];
                        end
                    end
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign LE   = le_q;
    assign DIR  = dir_q;
    assign DATO = dato_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule
